// File: rtl/decode_hold_buffer_if.sv
// decode_hold_pkg: micro-instruction types shared by the hold buffer and its neighbours.
// decode_hold_buffer_if: stall/flush, fetch-response and decode-side bundle of the
// decode hold buffer. The slave modport is the buffer; the master modport drives it.
package decode_hold_pkg;

    typedef enum logic [3:0] {
        MIOP_NOP    = 4'd0,
        MIOP_ALU    = 4'd1,
        MIOP_LOAD   = 4'd2,
        MIOP_STORE  = 4'd3,
        MIOP_BRANCH = 4'd4
    } miop_t;

    typedef struct packed {
        miop_t       op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } miinst_t;

    localparam miinst_t MIINST_NOP = '0;

endpackage

interface decode_hold_buffer_if #(
    parameter int FETCH_LATENCY = 2
) ();
    logic                               stall_pc;
    logic                               flush;
    logic                               fetch_valid;
    decode_hold_pkg::miinst_t           fetch_miinst;
    logic [63:0]                        fetch_pc;
    logic                               dec_valid;
    decode_hold_pkg::miinst_t           dec_miinst;
    logic [63:0]                        dec_pc;
    logic                               pc_enable;
    logic                               bubble;
    logic [$clog2(FETCH_LATENCY+1)-1:0] skid_count;
    logic                               overflow;

    modport master (
        output stall_pc, flush, fetch_valid, fetch_miinst, fetch_pc,
        input  dec_valid, dec_miinst, dec_pc, pc_enable, bubble, skid_count, overflow
    );

    modport slave (
        input  stall_pc, flush, fetch_valid, fetch_miinst, fetch_pc,
        output dec_valid, dec_miinst, dec_pc, pc_enable, bubble, skid_count, overflow
    );
endinterface

// File: rtl/decode_hold_buffer.sv
// decode_hold_buffer: freezes the decode register for LOAD_LATENCY cycles on a
// load-use stall, injects bubbles downstream, parks in-flight fetch responses in a
// skid FIFO of depth FETCH_LATENCY and drains them back into decode in order.
// Optional feature macro: HOLD_OVERFLOW_CHECK_EN (sticky overflow flag + assertion).
module decode_hold_buffer
    import decode_hold_pkg::*;
#(
    parameter int LOAD_LATENCY  = 1,
    parameter int FETCH_LATENCY = 2
) (
    input logic                 clk,
    input logic                 rstn,
    decode_hold_buffer_if.slave bus
);

    localparam int CW  = $clog2(LOAD_LATENCY + 1);
    localparam int SCW = $clog2(FETCH_LATENCY + 1);
    localparam int PW  = (FETCH_LATENCY > 1) ? $clog2(FETCH_LATENCY) : 1;

    typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

    typedef struct packed {
        miinst_t     inst;
        logic [63:0] pc;
    } skid_entry_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   hold_q, hold_d;
    skid_entry_t     mem [FETCH_LATENCY];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [SCW-1:0]  count;
    logic            frozen, load_fetch, do_pop, do_push, push_ok, full, hold_bubble;
    logic            dec_valid;
    miinst_t         dec_miinst;
    logic [63:0]     dec_pc;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FETCH_LATENCY - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next state, hold counter and decode-register steering for the hold FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_d     = state_q;
        hold_d      = hold_q;
        frozen      = 1'b0;
        load_fetch  = 1'b0;
        do_pop      = 1'b0;
        hold_bubble = 1'b0;
        if (bus.flush) begin
            state_d = RUN;
            hold_d  = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    frozen      = 1'b1;
                    hold_bubble = 1'b1;
                    if (hold_q <= CW'(1)) begin
                        state_d = DRAIN;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_q - 1'b1;
                    end
                end
                default: begin
                    if (bus.stall_pc) begin
                        frozen      = 1'b1;
                        hold_bubble = 1'b1;
                        hold_d      = CW'(LOAD_LATENCY - 1);
                        state_d     = (LOAD_LATENCY == 1) ? DRAIN : HOLD;
                    end else if (state_q == DRAIN && count != '0) begin
                        do_pop      = 1'b1;
                    end else begin
                        load_fetch  = 1'b1;
                        state_d     = RUN;
                    end
                end
            endcase
        end
    end

    // A full FIFO still accepts a push when the same edge pops the head.
    assign full    = (count == SCW'(FETCH_LATENCY));
    assign do_push = !bus.flush && bus.fetch_valid && (frozen || do_pop);
    assign push_ok = do_push && (!full || do_pop);

    // Reset gates the stall path so the outputs settle to idle without a clock edge.
    assign bus.bubble     = rstn && hold_bubble;
    assign bus.pc_enable  = !(rstn && hold_bubble);
    assign bus.skid_count = count;
    assign bus.dec_valid  = dec_valid;
    assign bus.dec_miinst = dec_miinst;
    assign bus.dec_pc     = dec_pc;

    // FSM state and hold counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
            hold_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Skid FIFO pointers and occupancy; flush empties it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push_ok && !do_pop)      count <= count + 1'b1;
            else if (!push_ok && do_pop) count <= count - 1'b1;
        end
    end

    // Skid FIFO storage.
    // NOTE: storage is not reset; count says which entries are live, stale ones are never read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {bus.fetch_miinst, bus.fetch_pc};
    end

    // Decode register: loads the fetch input, the FIFO head, or holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dec_valid  <= 1'b0;
            dec_miinst <= MIINST_NOP;
            dec_pc     <= '0;
        end else if (bus.flush) begin
            dec_valid  <= 1'b0;
            dec_miinst <= MIINST_NOP;
            dec_pc     <= '0;
        end else if (load_fetch) begin
            dec_valid  <= bus.fetch_valid;
            dec_miinst <= bus.fetch_miinst;
            dec_pc     <= bus.fetch_pc;
        end else if (do_pop) begin
            dec_valid  <= 1'b1;
            dec_miinst <= mem[rd_ptr].inst;
            dec_pc     <= mem[rd_ptr].pc;
        end
    end

`ifdef HOLD_OVERFLOW_CHECK_EN
    logic push_drop;
    logic overflow_q;

    assign push_drop    = do_push && full && !do_pop;
    assign bus.overflow = overflow_q;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          overflow_q <= 1'b0;
        else if (push_drop) overflow_q <= 1'b1;
    end

    overflow_check: assert property (@(posedge clk) disable iff (!rstn) !push_drop)
        else $error("decode_hold_buffer: skid FIFO full, fetch response dropped");
`else
    assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_decode_hold_buffer.sv
// Bench for decode_hold_buffer: two instances (LOAD_LATENCY 1 and 3) driven with
// directed and random stall/flush/fetch traffic, compared every cycle against a
// queue-style reference model of the hold behaviour.
module tb_decode_hold_buffer;
    import decode_hold_pkg::*;

    localparam int FL  = 2;
    localparam int SCW = $clog2(FL + 1);

    typedef struct packed {
        miinst_t     inst;
        logic [63:0] pc;
    } fetch_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    decode_hold_buffer_if #(.FETCH_LATENCY(FL)) bus0 ();
    decode_hold_buffer_if #(.FETCH_LATENCY(FL)) bus1 ();

    decode_hold_buffer #(.LOAD_LATENCY(1), .FETCH_LATENCY(FL)) dut0 (.clk(clk), .rstn(rstn), .bus(bus0));
    decode_hold_buffer #(.LOAD_LATENCY(3), .FETCH_LATENCY(FL)) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

    int n_vec = 0;
    int n_err = 0;

    // Stimulus
    int          fmode;              // 0: fetch follows pc_enable, 1: random, 2: forced on
    bit          stall [2];
    bit          flsh [2];
    bit          fv [2];
    fetch_t      fin [2];
    logic [63:0] next_pc [2];
    bit          pe_hist [2][FL];

    // Reference model
    int     lat [2] = '{1, 3};
    int     hold_left [2];          // remaining frozen cycles after the trigger cycle
    fetch_t fifo [2][FL];
    int     cnt [2];
    bit     m_valid [2];
    fetch_t m_dec [2];
    bit     m_ovf [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic miinst_t rand_inst();
        miinst_t i;
        i.op  = miop_t'(4'($urandom_range(0, 4)));
        i.rd  = 5'($urandom);
        i.rs1 = 5'($urandom);
        i.rs2 = 5'($urandom);
        i.imm = $urandom;
        return i;
    endfunction

    function automatic bit exp_bubble(int k);
        return rstn && !flsh[k] && (hold_left[k] > 0 || stall[k]);
    endfunction

    task automatic model_reset(int k);
        hold_left[k] = 0;
        cnt[k]       = 0;
        m_valid[k]   = 1'b0;
        m_dec[k]     = '0;
        m_ovf[k]     = 1'b0;
    endtask

    task automatic park(int k);
        if (fv[k]) begin
            if (cnt[k] < FL) begin
                fifo[k][cnt[k]] = fin[k];
                cnt[k]++;
            end else begin
                m_ovf[k] = 1'b1;
            end
        end
    endtask

    task automatic model_step(int k);
        bit pe;
        pe = !exp_bubble(k);
        for (int j = FL - 1; j > 0; j--) pe_hist[k][j] = pe_hist[k][j-1];
        pe_hist[k][0] = pe;
        if (flsh[k]) begin
            cnt[k]       = 0;
            hold_left[k] = 0;
            m_valid[k]   = 1'b0;
            m_dec[k]     = '0;
        end else if (hold_left[k] > 0) begin
            park(k);
            hold_left[k]--;
        end else if (stall[k]) begin
            park(k);
            hold_left[k] = lat[k] - 1;
        end else if (cnt[k] > 0) begin
            m_valid[k] = 1'b1;
            m_dec[k]   = fifo[k][0];
            for (int j = 0; j < FL - 1; j++) fifo[k][j] = fifo[k][j+1];
            cnt[k]--;
            park(k);
        end else begin
            m_valid[k] = fv[k];
            m_dec[k]   = fin[k];
        end
    endtask

    task automatic drive();
        bus0.stall_pc     = stall[0];
        bus0.flush        = flsh[0];
        bus0.fetch_valid  = fv[0];
        bus0.fetch_miinst = fin[0].inst;
        bus0.fetch_pc     = fin[0].pc;
        bus1.stall_pc     = stall[1];
        bus1.flush        = flsh[1];
        bus1.fetch_valid  = fv[1];
        bus1.fetch_miinst = fin[1].inst;
        bus1.fetch_pc     = fin[1].pc;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic           ob, ope, ov, oovf, eovf;
            logic [SCW-1:0] osk;
            logic [63:0]    opc;
            miinst_t        oin;
            if (k == 0) begin
                ob = bus0.bubble; ope = bus0.pc_enable; ov = bus0.dec_valid; oovf = bus0.overflow;
                osk = bus0.skid_count; opc = bus0.dec_pc; oin = bus0.dec_miinst;
            end else begin
                ob = bus1.bubble; ope = bus1.pc_enable; ov = bus1.dec_valid; oovf = bus1.overflow;
                osk = bus1.skid_count; opc = bus1.dec_pc; oin = bus1.dec_miinst;
            end
`ifdef HOLD_OVERFLOW_CHECK_EN
            eovf = m_ovf[k];
`else
            eovf = 1'b0;
`endif
            check($sformatf("i%0d bubble", k),     64'(ob),   64'(exp_bubble(k)));
            check($sformatf("i%0d pc_enable", k),  64'(ope),  64'(!exp_bubble(k)));
            check($sformatf("i%0d skid_count", k), 64'(osk),  64'(cnt[k]));
            check($sformatf("i%0d dec_valid", k),  64'(ov),   64'(m_valid[k]));
            check($sformatf("i%0d dec_pc", k),     opc,       m_dec[k].pc);
            check($sformatf("i%0d dec_miinst", k), 64'(oin),  64'(m_dec[k].inst));
            check($sformatf("i%0d overflow", k),   64'(oovf), 64'(eovf));
        end
    endtask

    // One clock: drive at the falling edge, compare, then advance the model.
    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            case (fmode)
                0:       fv[k] = pe_hist[k][FL-1];
                1:       fv[k] = 1'($urandom_range(0, 1));
                default: fv[k] = 1'b1;
            endcase
            fin[k].inst = rand_inst();
            fin[k].pc   = fv[k] ? next_pc[k] : 64'($urandom);
            if (fv[k]) next_pc[k] += 64'd4;
        end
        drive();
        #1;
        check_all();
        for (int k = 0; k < 2; k++) model_step(k);
    endtask

    task automatic quiet(int n);
        for (int i = 0; i < n; i++) begin
            stall = '{0, 0};
            flsh  = '{0, 0};
            cycle();
        end
    endtask

    initial begin
        int  peak;
        bit  fired0, fired1, b2b, hit;
        rstn  = 1'b0;
        fmode = 0;
        stall = '{0, 0};
        flsh  = '{0, 0};
        fv    = '{0, 0};
        for (int k = 0; k < 2; k++) begin
            fin[k]     = '0;
            next_pc[k] = 64'h10;
            for (int j = 0; j < FL; j++) pe_hist[k][j] = 1'b0;
            model_reset(k);
        end
        drive();
        #2;
        check_all();
        @(posedge clk);
        #2 rstn = 1'b1;

        // Stream from 0x10; stall when 0x10 sits in decode; instance 1 also
        // re-stalls on its first drain cycle.
        peak = 0; fired0 = 0; fired1 = 0; b2b = 0;
        for (int i = 0; i < 24; i++) begin
            stall[0] = !fired0 && m_valid[0] && m_dec[0].pc == 64'h10;
            stall[1] = (!fired1 && m_valid[1] && m_dec[1].pc == 64'h10) ||
                       (fired1 && !b2b && hold_left[1] == 0 && cnt[1] > 0);
            if (fired1 && stall[1]) b2b = 1;
            if (stall[0]) fired0 = 1;
            if (stall[1]) fired1 = 1;
            flsh = '{0, 0};
            cycle();
            if (int'(bus1.skid_count) > peak) peak = int'(bus1.skid_count);
        end
        check("i1 skid peak", 64'(peak), 64'd2);
        check("i1 back-to-back seen", 64'(b2b), 64'd1);

        // Flush together with stall while the skid FIFO holds two entries.
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            flsh  = '{0, 0};
            stall = '{0, 0};
            if (cnt[1] == FL) begin
                stall[1] = 1;
                flsh[1]  = 1;
                hit      = 1;
            end else if (hold_left[1] == 0 && cnt[1] == 0 && m_valid[1]) begin
                stall[1] = 1;
            end
            cycle();
        end
        check("i1 reached skid=2 for flush", 64'(hit), 64'd1);
        quiet(6);

        // Forced third push into a full FIFO.
        fmode = 2;
        stall = '{0, 1};
        flsh  = '{0, 0};
        cycle();
        quiet(8);
        fmode = 0;
        quiet(6);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            if (i % 50 == 0) fmode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            for (int k = 0; k < 2; k++) begin
                stall[k] = $urandom_range(0, 99) < 15;
                flsh[k]  = $urandom_range(0, 99) < 3;
            end
            cycle();
        end
        fmode = 0;
        quiet(10);

        // Asynchronous reset while instance 1 is in HOLD.
        stall = '{0, 1};
        flsh  = '{0, 0};
        cycle();
        check("i1 in hold before reset", 64'(hold_left[1] > 0), 64'd1);
        @(negedge clk);
        stall = '{0, 0};
        drive();
        #2 rstn = 1'b0;
        for (int k = 0; k < 2; k++) model_reset(k);
        #1;
        check_all();
        @(posedge clk);
        #2 rstn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 2; k++) begin
                stall[k] = $urandom_range(0, 99) < 10;
                flsh[k]  = 1'b0;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
